// File: rtl/rsa_pkg.sv
// Shared RSA constants, command encodings, FSM state type and the
// interleaved modular-multiply step used by the encryption/decryption engines.
package rsa_pkg;

  localparam int DATA_W = 13;
  localparam int EXP_W  = 13;
  localparam int OUT_W  = 16;
  localparam int CMD_W  = 3;
  localparam int CNT_W  = 4;

  localparam logic [DATA_W-1:0] DEFAULT_D = 13'd2753;
  localparam logic [DATA_W-1:0] DEFAULT_N = 13'd3233;

  localparam logic [CMD_W-1:0] CMD_IDLE   = 3'd0;
  localparam logic [CMD_W-1:0] CMD_START  = 3'd1;
  localparam logic [CMD_W-1:0] CMD_LOAD_D = 3'd2;
  localparam logic [CMD_W-1:0] CMD_LOAD_N = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_BIT_START,
    ST_BIT_RUN,
    ST_DONE
  } state_t;

  // One MSB-first step: acc <- (2*acc + bit*a) mod n, with acc and a both < n.
  function automatic logic [DATA_W-1:0] mod_step(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] n,
    input logic              b
  );
    logic [DATA_W:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    if (b) t = t + {1'b0, a};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    return t[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/rsa_decryptor_if.sv
// Command/data bus of the RSA decryptor: operand and command in, result and status out.
interface rsa_decryptor_if;
  import rsa_pkg::*;

  logic [DATA_W-1:0] data;
  logic [CMD_W-1:0]  input_data_type;
  logic [OUT_W-1:0]  output_data;
  logic              done;
  logic              busy;
  logic              error;

  modport master (
    output data, input_data_type,
    input  output_data, done, busy, error
  );

  modport slave (
    input  data, input_data_type,
    output output_data, done, busy, error
  );

endinterface

// File: rtl/rsa_mod_mul.sv
// Sequential interleaved modular multiplier, one bit of b per cycle, MSB first.
// The first bit is consumed on the start edge, so valid pulses DATA_W cycles after start.
module rsa_mod_mul
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] n,
  output logic [DATA_W-1:0] p,
  output logic              valid
);

  logic [DATA_W-1:0] a_r, b_r, n_r, acc, acc_next;
  logic [CNT_W-1:0]  cnt;
  logic              running;

  assign acc_next = mod_step(acc, a_r, n_r, b_r[DATA_W-1]);
  assign p        = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      n_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        a_r     <= a;
        n_r     <= n;
        b_r     <= {b[DATA_W-2:0], 1'b0};
        acc     <= mod_step('0, a, n, b[DATA_W-1]);
        cnt     <= CNT_W'(DATA_W - 1);
        running <= 1'b1;
      end else if (running) begin
        acc <= acc_next;
        b_r <= {b_r[DATA_W-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_decryptor.sv
// RSA decryption engine: m = c^d mod n by constant-time right-to-left
// square-and-multiply, with loadable key registers.
module rsa_decryptor
  import rsa_pkg::*;
(
  input logic            clk,
  input logic            reset,
  rsa_decryptor_if.slave bus
);

  state_t state, next_state;

  logic [DATA_W-1:0] key_d, key_n, c_reg, result, base, exp_reg;
  logic [DATA_W-1:0] p_a, p_b;
  logic [CNT_W-1:0]  bit_cnt;
  logic              mul_start, valid_a, valid_b;
  logic              reject, last_bit, mul_done;

  assign reject   = bus.data >= key_n;
  assign last_bit = bit_cnt == CNT_W'(EXP_W - 1);
  assign mul_done = valid_a && valid_b;

  rsa_mod_mul u_mul (
    .clk(clk), .reset(reset), .start(mul_start),
    .a(result), .b(base), .n(key_n), .p(p_a), .valid(valid_a)
  );

  rsa_mod_mul u_sqr (
    .clk(clk), .reset(reset), .start(mul_start),
    .a(base), .b(base), .n(key_n), .p(p_b), .valid(valid_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.input_data_type == CMD_START)
          next_state = reject ? ST_DONE : ST_INIT;
      end
      ST_INIT:      next_state = ST_BIT_START;
      ST_BIT_START: begin
        mul_start  = 1'b1;
        next_state = ST_BIT_RUN;
      end
      ST_BIT_RUN: begin
        if (mul_done) next_state = last_bit ? ST_DONE : ST_BIT_START;
      end
      default:      next_state = ST_IDLE;
    endcase
  end

  // Commands are only honoured between decryptions, so key registers are stable while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_d           <= DEFAULT_D;
      key_n           <= DEFAULT_N;
      c_reg           <= '0;
      result          <= '0;
      base            <= '0;
      exp_reg         <= '0;
      bit_cnt         <= '0;
      bus.output_data <= '0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.error       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          case (bus.input_data_type)
            CMD_LOAD_D: key_d <= bus.data;
            CMD_LOAD_N: if (bus.data >= DATA_W'(2)) key_n <= bus.data;
            CMD_START: begin
              if (reject) begin
                bus.error       <= 1'b1;
                bus.done        <= 1'b1;
                bus.busy        <= 1'b0;
                bus.output_data <= '0;
              end else begin
                c_reg     <= bus.data;
                bus.error <= 1'b0;
                bus.done  <= 1'b0;
                bus.busy  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_INIT: begin
          result  <= DATA_W'(1);
          base    <= c_reg;
          exp_reg <= key_d;
          bit_cnt <= '0;
        end
        ST_BIT_RUN: begin
          if (mul_done) begin
            if (exp_reg[0]) result <= p_a;
            base    <= p_b;
            exp_reg <= exp_reg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              bus.output_data <= {{(OUT_W-DATA_W){1'b0}}, (exp_reg[0] ? p_a : result)};
              bus.done        <= 1'b1;
              bus.busy        <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
